sevenseg4_enc: RTL
==================

SEVENSEG4_ENC -- requirements
Module: sevenseg4_enc

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clock cycles each digit is driven (legal range >= 2).
REQ-002 SHALL have parameter BLINK_DIV, default 12_500_000, clock cycles per blink half-period (legal range >= 2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load  input  1  single-cycle request to capture digits.
REQ-006 SHALL have port digits  input  16  four BCD nibbles; [3:0] = digit 0 (rightmost), [15:12] = digit 3 (leftmost).
REQ-007 SHALL have port blank_lz  input  1  leading-zero blanking enable.
REQ-008 SHALL have port blink  input  1  blink enable.
REQ-009 SHALL have port ack  output  1  one-cycle pulse confirming a capture.
REQ-010 SHALL have port seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-011 SHALL have port an  output  4  active-low digit select, an[k] drives digit k.

Function
REQ-012 SHALL hold a 16-bit shadow register; when load=1 at an edge, shadow <= digits; ack=1 in the next cycle only; back-to-back loads each capture and each produce an ack.
REQ-013 SHALL run a scan counter 0..SCAN_DIV-1, wrapping; when it is at SCAN_DIV-1, the digit index advances 0->1->2->3->0.
REQ-014 SHALL register seg and an; both reflect the index and shadow of the previous cycle (one-cycle latency), so new digits appear on seg two cycles after the load edge.
REQ-015 SHALL drive an with exactly one low bit, an[index]=0, when not blink-dark.
REQ-016 SHALL encode nibble values (seg, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000.
REQ-017 SHALL encode nibble values 10..15 as error glyph 'E' = 0000110.
REQ-018 SHALL, when blank_lz=1, drive seg=1111111 for digit k (k=1..3) iff every nibble k..3 equals 0; digit 0 SHALL never be blanked; an remains normally scanned.
REQ-019 SHALL not treat non-zero invalid nibbles (10..15) as zero for blanking.
REQ-020 SHALL, when blink=1, run a blink counter 0..BLINK_DIV-1 toggling phase at wrap; phase=1 forces seg=1111111 and an=1111; scan continues underneath.
REQ-021 SHALL hold blink counter and phase at 0 while blink=0, so asserting blink starts with a full lit half-period.
REQ-022 SHALL apply load regardless of blink phase or scan position; scan timing SHALL not be disturbed by load.

Reset
REQ-023 SHALL on reset=1 at an edge set: shadow=0, index=0, scan counter=0, blink counter=0, phase=0, ack=0, seg=1111111, an=1111.
REQ-024 SHALL give reset priority over load; a load coincident with reset is discarded and produces no ack.
REQ-025 SHALL, in the first cycle after reset deasserts, present seg=1111111/an=1111; from the second cycle, seg=1000000, an=1110 (digit 0 = '0').

Verification (SCAN_DIV=4, BLINK_DIV=8)
REQ-026 SHALL verify reset release, no load, blank_lz=0 -> seg=1000000 throughout; an sequence 1110,1101,1011,0111 each held 4 cycles, repeating.
REQ-027 SHALL verify load digits=16'h1234 -> ack high exactly one cycle; digit 0 seg=0011001 with an=1110; digit 3 seg=1111001 with an=0111.
REQ-028 SHALL verify blank_lz=1, load 16'h0050 -> digits 3,2 seg=1111111; digit 1 seg=0010010; digit 0 seg=1000000; load 16'h0000 -> only digit 0 lit.
REQ-029 SHALL verify load 16'h00A0, blank_lz=1 -> digit 1 seg=0000110 ('E'), digits 3,2 blank, digit 0 seg=1000000.
REQ-030 SHALL verify blink=1 -> 8 cycles lit, 8 cycles seg=1111111/an=1111, alternating; blink=0 -> continuously lit next cycle.
REQ-031 SHALL verify reset asserted while index=2 with shadow=16'h1234, simultaneous load -> next cycle seg=1111111, an=1111, ack=0; after release digit 0 shows '0'.

Source files
------------

// File: rtl/sevenseg4_enc.sv
// Four-digit multiplexed seven-segment encoder.
// Holds a BCD shadow register loaded on request, scans one digit at a time,
// optionally blanks leading zeros and blinks the whole display.
// Segment and anode outputs are registered, so they show the scan index and
// shadow contents from the previous cycle.
module sevenseg4_enc #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] digits,
  input  logic        blank_lz,
  input  logic        blink,
  output logic        ack,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ERROR = 7'b0000110;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Captured digits and the acknowledge pulse
  logic [15:0]        shadow_q,     shadow_d;
  logic               ack_q,        ack_d;

  // Digit scan timing
  logic [SCAN_W-1:0]  scanCnt_q,    scanCnt_d;
  logic [1:0]         digitIdx_q,   digitIdx_d;

  // Blink timing
  logic [BLINK_W-1:0] blinkCnt_q,   blinkCnt_d;
  logic               blinkPhase_q, blinkPhase_d;

  // Registered display drive
  logic [6:0]         seg_q,        seg_d;
  logic [3:0]         an_q,         an_d;

  // Combinational helpers for the display path
  logic [3:0]         curNibble;
  logic               zeroFrom1;
  logic               zeroFrom2;
  logic               zeroFrom3;
  logic               leadBlank;
  logic [3:0]         anSelect;
  logic               blinkDark;

  // Active-low glyph for one nibble; anything above 9 shows an 'E'
  function automatic logic [6:0] encodeNibble(input logic [3:0] nibble);
    logic [6:0] glyph;
    case (nibble)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0011000;
      default: glyph = SEG_ERROR;
    endcase
    return glyph;
  endfunction

  // Capture new digits on a load request and echo it as a one-cycle ack
  always_comb begin
    shadow_d = shadow_q;
    ack_d    = load;
    if (load) begin
      shadow_d = digits;
    end
  end

  // Scan counter dwells SCAN_DIV cycles per digit, then steps the index
  always_comb begin
    scanCnt_d  = scanCnt_q + SCAN_W'(1);
    digitIdx_d = digitIdx_q;
    if (scanCnt_q == SCAN_LAST) begin
      scanCnt_d  = '0;
      digitIdx_d = digitIdx_q + 2'd1;
    end
  end

  // Blink counter runs only while blinking and restarts lit when re-enabled
  always_comb begin
    blinkCnt_d   = '0;
    blinkPhase_d = 1'b0;
    if (blink) begin
      blinkPhase_d = blinkPhase_q;
      if (blinkCnt_q == BLINK_LAST) begin
        blinkCnt_d   = '0;
        blinkPhase_d = ~blinkPhase_q;
      end else begin
        blinkCnt_d = blinkCnt_q + BLINK_W'(1);
      end
    end
  end

  // Pick the nibble and anode for the digit currently being scanned
  always_comb begin
    curNibble = shadow_q[3:0];
    anSelect  = 4'b1110;
    case (digitIdx_q)
      2'd1: begin
        curNibble = shadow_q[7:4];
        anSelect  = 4'b1101;
      end
      2'd2: begin
        curNibble = shadow_q[11:8];
        anSelect  = 4'b1011;
      end
      2'd3: begin
        curNibble = shadow_q[15:12];
        anSelect  = 4'b0111;
      end
      default: begin
        curNibble = shadow_q[3:0];
        anSelect  = 4'b1110;
      end
    endcase
  end

  // A digit is a leading zero only if it and every digit to its left are
  // exactly zero; invalid nibbles count as non-zero, digit 0 is never blanked
  always_comb begin
    zeroFrom3 = (shadow_q[15:12] == 4'h0);
    zeroFrom2 = zeroFrom3 && (shadow_q[11:8] == 4'h0);
    zeroFrom1 = zeroFrom2 && (shadow_q[7:4] == 4'h0);
    leadBlank = 1'b0;
    if (blank_lz) begin
      case (digitIdx_q)
        2'd1:    leadBlank = zeroFrom1;
        2'd2:    leadBlank = zeroFrom2;
        2'd3:    leadBlank = zeroFrom3;
        default: leadBlank = 1'b0;
      endcase
    end
  end

  // Compose the next display drive; the dark blink phase overrides everything
  always_comb begin
    blinkDark = blink && blinkPhase_q;
    seg_d     = encodeNibble(curNibble);
    an_d      = anSelect;
    if (leadBlank) begin
      seg_d = SEG_BLANK;
    end
    if (blinkDark) begin
      seg_d = SEG_BLANK;
      an_d  = AN_OFF;
    end
  end

  // State register with synchronous reset; reset also wins over a load
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q     <= 16'h0000;
      ack_q        <= 1'b0;
      scanCnt_q    <= '0;
      digitIdx_q   <= 2'd0;
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= AN_OFF;
    end else begin
      shadow_q     <= shadow_d;
      ack_q        <= ack_d;
      scanCnt_q    <= scanCnt_d;
      digitIdx_q   <= digitIdx_d;
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign ack = ack_q;
  assign seg = seg_q;
  assign an  = an_q;

endmodule
